// File: rtl/rvfpm_pkg.sv
// -----------------------------------------------------------------------------
// rvfpm_pkg
// Shared types and constants for the rvfpm issue path.
//   RVFPM_XLEN        : instruction word width held in each queue entry
//   RVFPM_X_ID_WIDTH  : XIF instruction id width held in each queue entry
//   RVFPM_QUEUE_DEPTH : default number of buffered offload entries
//   ptr_width()       : read/write pointer width for a given queue depth
//   entry_t           : one issue-queue slot (instr, id, valid, committed, killed)
// -----------------------------------------------------------------------------
package rvfpm_pkg;

    localparam int unsigned RVFPM_XLEN        = 32'd32;
    localparam int unsigned RVFPM_X_ID_WIDTH  = 32'd4;
    localparam int unsigned RVFPM_QUEUE_DEPTH = 32'd4;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    // The issue controller's XLEN / X_ID_WIDTH parameters must equal these
    // constants, since the slot layout is fixed here.
    typedef struct packed {
        logic [RVFPM_XLEN-1:0]       instr;
        logic [RVFPM_X_ID_WIDTH-1:0] id;
        logic                        valid;
        logic                        committed;
        logic                        killed;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/rvfpm_issue_ctrl.sv
// -----------------------------------------------------------------------------
// rvfpm_issue_ctrl
// In-order issue queue between the CORE-V-XIF offload port and the rvfpm FPU.
// Offloaded instructions are buffered with their ids; commit/kill events are
// matched against the buffered ids (CAM); only committed heads are dispatched,
// killed heads are retired silently at one entry per cycle.
//
// Ports
//   ck, rst                  clock, asynchronous active-low reset
//   issue_valid/ready        offload handshake; issue_instr, issue_id payload
//   commit_valid, commit_id  commit/kill event for one id; commit_kill = 1 kills
//   flush                    discard every queued entry (highest priority)
//   fpu_valid/ready          dispatch handshake; fpu_instr, fpu_id from head
//   count                    registered occupancy
//   commit_miss              registered one-cycle pulse: commit id not found
// -----------------------------------------------------------------------------
module rvfpm_issue_ctrl
    import rvfpm_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH  = RVFPM_X_ID_WIDTH,
    parameter int unsigned QUEUE_DEPTH = RVFPM_QUEUE_DEPTH,
    parameter int unsigned XLEN        = RVFPM_XLEN
) (
    input  logic                         ck,
    input  logic                         rst,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [XLEN-1:0]              issue_instr,
    input  logic [X_ID_WIDTH-1:0]        issue_id,
    input  logic                         commit_valid,
    input  logic [X_ID_WIDTH-1:0]        commit_id,
    input  logic                         commit_kill,
    input  logic                         flush,
    output logic                         fpu_valid,
    input  logic                         fpu_ready,
    output logic [XLEN-1:0]              fpu_instr,
    output logic [X_ID_WIDTH-1:0]        fpu_id,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic                         commit_miss
);

    localparam int unsigned PTR_W   = ptr_width(QUEUE_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 32'd1;
    localparam int          DEPTH_I = int'(QUEUE_DEPTH);

    entry_t                  entries_r     [QUEUE_DEPTH];
    entry_t                  entries_nxt_s [QUEUE_DEPTH];
    logic [PTR_W-1:0]        head_r;
    logic [PTR_W-1:0]        tail_r;
    logic [PTR_W-1:0]        head_nxt_s;
    logic [PTR_W-1:0]        tail_nxt_s;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_nxt_s;
    logic                    commit_miss_r;

    entry_t                  head_entry_s;
    entry_t                  new_entry_s;
    logic [QUEUE_DEPTH-1:0]  match_vec_s;
    logic                    full_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    dispatch_s;
    logic                    kill_pop_s;
    logic                    hit_new_s;
    logic                    miss_s;

    // Head decode, handshakes and dispatch outputs.
    always_comb begin
        head_entry_s = entries_r[head_r];
        full_s       = (count_r == CNT_W'(QUEUE_DEPTH));
        // No same-cycle full bypass: a pop while full still refuses the issue.
        issue_ready  = !full_s && !flush;
        push_s       = issue_valid && issue_ready;
        // Dispatch and silent retirement both look only at registered flags,
        // so a commit landing this cycle is seen at the head one cycle later.
        dispatch_s   = !flush && head_entry_s.valid && head_entry_s.committed
                       && !head_entry_s.killed;
        kill_pop_s   = !flush && head_entry_s.valid && head_entry_s.killed;
        pop_s        = (dispatch_s && fpu_ready) || kill_pop_s;
        fpu_valid    = dispatch_s;
        if (dispatch_s) begin
            fpu_instr = head_entry_s.instr;
            fpu_id    = head_entry_s.id;
        end else begin
            fpu_instr = {XLEN{1'b0}};
            fpu_id    = {X_ID_WIDTH{1'b0}};
        end
    end

    // Commit CAM: associative id search over valid entries plus the entry
    // being written this cycle (bypass), and miss detection.
    always_comb begin
        match_vec_s = {QUEUE_DEPTH{1'b0}};
        for (int i = 0; i < DEPTH_I; i++) begin
            match_vec_s[i] = commit_valid && entries_r[i].valid
                             && (entries_r[i].id == commit_id);
        end
        hit_new_s = commit_valid && push_s && (issue_id == commit_id);
        miss_s    = commit_valid && !flush && !(|match_vec_s) && !hit_new_s;
    end

    // Slot image written at the tail on an accepted issue.
    always_comb begin
        new_entry_s           = {ENTRY_W{1'b0}};
        new_entry_s.instr     = issue_instr;
        new_entry_s.id        = issue_id;
        new_entry_s.valid     = 1'b1;
        new_entry_s.committed = hit_new_s && !commit_kill;
        new_entry_s.killed    = hit_new_s && commit_kill;
    end

    // Next-state for storage, pointers and occupancy; flush overrides all.
    always_comb begin
        for (int i = 0; i < DEPTH_I; i++) begin
            entries_nxt_s[i] = entries_r[i];
        end
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (flush) begin
            for (int i = 0; i < DEPTH_I; i++) begin
                entries_nxt_s[i].valid     = 1'b0;
                entries_nxt_s[i].committed = 1'b0;
                entries_nxt_s[i].killed    = 1'b0;
            end
            head_nxt_s  = {PTR_W{1'b0}};
            tail_nxt_s  = {PTR_W{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            // Ids are unique, so at most one slot matches.
            for (int i = 0; i < DEPTH_I; i++) begin
                if (match_vec_s[i]) begin
                    if (commit_kill) begin
                        entries_nxt_s[i].killed = 1'b1;
                    end else begin
                        entries_nxt_s[i].committed = 1'b1;
                    end
                end else begin
                    entries_nxt_s[i].valid = entries_r[i].valid;
                end
            end
            // Popping applies after the commit update; push never targets
            // the head slot while it is valid because push requires !full.
            if (pop_s) begin
                entries_nxt_s[head_r].valid = 1'b0;
                head_nxt_s                  = head_r + PTR_W'(1'b1);
            end else begin
                head_nxt_s = head_r;
            end
            if (push_s) begin
                entries_nxt_s[tail_r] = new_entry_s;
                tail_nxt_s            = tail_r + PTR_W'(1'b1);
            end else begin
                tail_nxt_s = tail_r;
            end
            count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // State registers with asynchronous clear of every slot.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_I; i++) begin
                entries_r[i] <= {ENTRY_W{1'b0}};
            end
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            commit_miss_r <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH_I; i++) begin
                entries_r[i] <= entries_nxt_s[i];
            end
            head_r        <= head_nxt_s;
            tail_r        <= tail_nxt_s;
            count_r       <= count_nxt_s;
            commit_miss_r <= miss_s;
        end
    end

    assign count       = count_r;
    assign commit_miss = commit_miss_r;

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
module tb_rvfpm_issue_ctrl;

    localparam int QD = 4;

    logic        ck = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [3:0]  issue_id;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        flush;
    logic        fpu_valid;
    logic        fpu_ready;
    logic [31:0] fpu_instr;
    logic [3:0]  fpu_id;
    logic [2:0]  count;
    logic        commit_miss;

    always #5 ck = ~ck;

    rvfpm_issue_ctrl dut (
        .ck(ck), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_id(issue_id),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .flush(flush),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
        .fpu_instr(fpu_instr), .fpu_id(fpu_id),
        .count(count), .commit_miss(commit_miss)
    );

    // Reference model: an ordered list of outstanding instructions.
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  id;
        bit          com;
        bit          kil;
    } ref_t;

    ref_t       mq[$];
    bit         miss_m;
    logic [3:0] disp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_q(input logic [3:0] id);
        foreach (mq[i]) if (mq[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive at negedge, check against the model, advance model.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [3:0] iid,
                       input logic cv, input logic [3:0] cid, input logic kl,
                       input logic fl, input logic fr);
        bit   exp_rdy, exp_fv, push, pop, found, hit_new;
        int   fidx, dup;
        ref_t ne;
        issue_valid = iv; issue_instr = ins; issue_id = iid;
        commit_valid = cv; commit_id = cid; commit_kill = kl;
        flush = fl; fpu_ready = fr;
        #1;
        exp_rdy = (mq.size() < QD) && !fl;
        exp_fv  = !fl && (mq.size() > 0) && mq[0].com && !mq[0].kil;
        check("issue_ready", 32'(issue_ready), 32'(exp_rdy));
        check("fpu_valid", 32'(fpu_valid), 32'(exp_fv));
        if (exp_fv) begin
            check("fpu_id", 32'(fpu_id), 32'(mq[0].id));
            check("fpu_instr", fpu_instr, mq[0].instr);
        end
        check("count", 32'(count), 32'(mq.size()));
        check("commit_miss", 32'(commit_miss), 32'(miss_m));
        if (fpu_valid && fpu_ready) disp_q.push_back(fpu_id);
        if (fl) begin
            mq.delete();
            miss_m = 1'b0;
        end else begin
            push  = iv && exp_rdy;
            pop   = (mq.size() > 0) && (mq[0].kil || (exp_fv && fr));
            found = 1'b0;
            fidx  = 0;
            foreach (mq[i]) if (mq[i].id == cid) begin found = 1'b1; fidx = i; end
            hit_new = cv && push && (iid == cid);
            if (cv && found) begin
                if (kl) mq[fidx].kil = 1'b1;
                else    mq[fidx].com = 1'b1;
            end
            miss_m = cv && !found && !hit_new;
            if (pop) void'(mq.pop_front());
            if (push) begin
                ne.instr = ins; ne.id = iid;
                ne.com = hit_new && !kl;
                ne.kil = hit_new && kl;
                mq.push_back(ne);
            end
        end
        dup = 0;
        for (int i = 0; i < mq.size(); i++)
            for (int j = i + 1; j < mq.size(); j++)
                if (mq[i].id == mq[j].id) dup++;
        check("uniq_ids", 32'(dup), 32'd0);
        @(posedge ck);
        @(negedge ck);
        issue_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input logic fr);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, fr);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_issue_ready"}, 32'(issue_ready), 32'd1);
        check({tag, "_fpu_valid"}, 32'(fpu_valid), 32'd0);
        check({tag, "_fpu_instr"}, fpu_instr, 32'd0);
        check({tag, "_fpu_id"}, 32'(fpu_id), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_commit_miss"}, 32'(commit_miss), 32'd0);
    endtask

    initial begin
        int          n6;
        logic [3:0]  iid, cid;
        logic        iv, cv, kl, fl, fr;

        rst = 1'b0;
        issue_valid = 1'b0; issue_instr = 32'h0; issue_id = 4'h0;
        commit_valid = 1'b0; commit_id = 4'h0; commit_kill = 1'b0;
        flush = 1'b0; fpu_ready = 1'b0;
        miss_m = 1'b0;
        @(negedge ck);
        reset_checks("reset");
        rst = 1'b1;
        @(negedge ck);

        // Issue then commit: single dispatch, queue drains.
        cyc(1'b1, 32'h0000_0053, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        check("t1_fpu_valid", 32'(fpu_valid), 32'd1);
        check("t1_fpu_id", 32'(fpu_id), 32'd1);
        check("t1_fpu_instr", fpu_instr, 32'h0000_0053);
        idle(1'b1);
        check("t1_fpu_valid_drop", 32'(fpu_valid), 32'd0);
        check("t1_count", 32'(count), 32'd0);

        // Fill, commit out of order, dispatch strictly in order.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'h100 + 32'(i), 4'(i), 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("t2_full_ready", 32'(issue_ready), 32'd0);
        check("t2_full_count", 32'(count), 32'd4);
        disp_q.delete();
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        check("t2_head_stall", 32'(fpu_valid), 32'd0);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("t2_disp_n", 32'(disp_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < disp_q.size(); i++)
            check("t2_disp_order", 32'(disp_q[i]), 32'(i));

        // Same-cycle issue + commit bypass.
        cyc(1'b1, 32'h0000_00A5, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
        check("t3_bypass_valid", 32'(fpu_valid), 32'd1);
        check("t3_bypass_id", 32'(fpu_id), 32'd5);
        idle(1'b1);

        // Kill 6, commit 7: 6 never dispatched.
        disp_q.delete();
        cyc(1'b1, 32'h66, 4'd6, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h77, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1);
        check("t4_valid7", 32'(fpu_valid), 32'd1);
        check("t4_id7", 32'(fpu_id), 32'd7);
        idle(1'b1);
        n6 = 0;
        foreach (disp_q[i]) if (disp_q[i] == 4'd6) n6++;
        check("t4_no_id6", 32'(n6), 32'd0);
        check("t4_disp_n", 32'(disp_q.size()), 32'd1);

        // Commit miss on empty queue.
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        check("t5_miss_pulse", 32'(commit_miss), 32'd1);
        check("t5_miss_count", 32'(count), 32'd0);
        idle(1'b1);
        check("t5_miss_drop", 32'(commit_miss), 32'd0);

        // Flush with three entries, one of them dispatchable.
        cyc(1'b1, 32'hA0, 4'd10, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA1, 4'd11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA2, 4'd12, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("t6_pre_count", 32'(count), 32'd3);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        check("t6_flush_count", 32'(count), 32'd0);
        check("t6_flush_valid", 32'(fpu_valid), 32'd0);

        // Stall with committed head, then asynchronous reset mid-stall.
        cyc(1'b1, 32'hDEAD_BEEF, 4'd13, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("t7_stall_valid", 32'(fpu_valid), 32'd1);
            check("t7_stall_instr", fpu_instr, 32'hDEAD_BEEF);
            check("t7_stall_id", 32'(fpu_id), 32'd13);
            idle(1'b0);
        end
        rst = 1'b0;
        #1;
        reset_checks("midrst");
        mq.delete();
        miss_m = 1'b0;
        @(negedge ck);
        rst = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            iv = ($urandom_range(0, 99) < 60);
            do iid = 4'($urandom_range(0, 15)); while (in_q(iid));
            cv = ($urandom_range(0, 99) < 50);
            if (mq.size() > 0 && $urandom_range(0, 99) < 75)
                cid = mq[$urandom_range(0, mq.size() - 1)].id;
            else if (iv && $urandom_range(0, 99) < 50)
                cid = iid;
            else
                cid = 4'($urandom_range(0, 15));
            kl = ($urandom_range(0, 99) < 25);
            fl = ($urandom_range(0, 99) < 3);
            fr = ($urandom_range(0, 99) < 70);
            cyc(iv, $urandom, iid, cv, cid, kl, fl, fr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
